// File: rtl/i2s_capture_ctrl.sv
// I2S microphone capture session sequencer: aligns to a frame, drops warm-up pairs,
// then forwards a counted (or continuous) run of 24-bit L/R pairs through a small FIFO.
//
// state   | meaning
// IDLE    | waiting for start_i
// SYNC    | clock generator running, waiting for the first frame boundary
// DISCARD | dropping the first DISCARD_PAIRS completed pairs
// STREAM  | pushing pairs into the FIFO until the target count or stop_i
// DRAIN   | no more pushes, waiting for the consumer to empty the FIFO
// DONE    | one-cycle end-of-session marker
module i2s_capture_ctrl #(
   parameter int FIFO_DEPTH    = 4,
   parameter int DISCARD_PAIRS = 2,
   parameter int CNT_W         = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic [CNT_W-1:0] num_pairs_i,
   input  logic             frame_start_i,
   input  logic             pair_ready_i,
   input  logic [23:0]      left_i,
   input  logic [23:0]      right_i,
   output logic             sck_en_o,
   output logic             pcm_valid_o,
   output logic [23:0]      pcm_left_o,
   output logic [23:0]      pcm_right_o,
   input  logic             pcm_ready_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             overflow_o,
   output logic [CNT_W-1:0] pair_count_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = (DISCARD_PAIRS > 1) ? $clog2(DISCARD_PAIRS) : 1;
   localparam logic [DW-1:0] DISC_LAST = DW'((DISCARD_PAIRS > 0) ? DISCARD_PAIRS - 1 : 0);
   localparam logic [AW:0]   PTR_ONE   = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_DISCARD,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] target;
   logic [DW-1:0]    disc_cnt;

   logic [47:0]      mem [FIFO_DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             empty;
   logic             full;
   logic             pop;
   logic             pair_in;
   logic             push;
   logic             drop;
   logic [47:0]      head;
   logic [CNT_W-1:0] count_nxt;
   logic             target_hit;

   // The extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = !empty && pcm_ready_i;
   assign pair_in = (state == S_STREAM) && pair_ready_i;
   assign push    = pair_in && (!full || pop);
   assign drop    = pair_in && full && !pop;

   assign head        = mem[rd_ptr[AW-1:0]];
   assign pcm_valid_o = !empty;
   assign pcm_left_o  = empty ? 24'd0 : head[47:24];
   assign pcm_right_o = empty ? 24'd0 : head[23:0];

   assign count_nxt  = pair_count_o + CNT_ONE;
   assign target_hit = push && (target != '0) && (count_nxt == target);

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {left_i, right_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state        <= S_IDLE;
         target       <= '0;
         disc_cnt     <= '0;
         sck_en_o     <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         overflow_o   <= 1'b0;
         pair_count_o <= '0;
      end else begin
         done_o <= 1'b0;
         if (drop) begin
            overflow_o <= 1'b1;
         end
         // Saturates only in continuous mode; a nonzero target stops the count first.
         if (push && (pair_count_o != '1)) begin
            pair_count_o <= count_nxt;
         end
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  target       <= num_pairs_i;
                  pair_count_o <= '0;
                  overflow_o   <= 1'b0;
                  disc_cnt     <= '0;
                  sck_en_o     <= 1'b1;
                  busy_o       <= 1'b1;
                  state        <= S_SYNC;
               end
            end
            S_SYNC: begin
               if (stop_i) begin
                  sck_en_o <= 1'b0;
                  state    <= S_DRAIN;
               end else if (frame_start_i) begin
                  state <= (DISCARD_PAIRS == 0) ? S_STREAM : S_DISCARD;
               end
            end
            S_DISCARD: begin
               if (stop_i) begin
                  sck_en_o <= 1'b0;
                  state    <= S_DRAIN;
               end else if (pair_ready_i) begin
                  if (disc_cnt == DISC_LAST) begin
                     state <= S_STREAM;
                  end else begin
                     disc_cnt <= disc_cnt + 1'b1;
                  end
               end
            end
            S_STREAM: begin
               if (stop_i || target_hit) begin
                  sck_en_o <= 1'b0;
                  state    <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (empty) begin
                  done_o <= 1'b1;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               sck_en_o <= 1'b0;
               busy_o   <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Directed bench for i2s_capture_ctrl: table-driven capture session plus
// hand-written sequences for overflow, stop, reset and start-while-busy corners.
module tb_i2s_capture_ctrl;

   localparam int CNT_W = 16;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             start_i;
   logic             stop_i;
   logic [CNT_W-1:0] num_pairs_i;
   logic             frame_start_i;
   logic             pair_ready_i;
   logic [23:0]      left_i;
   logic [23:0]      right_i;
   logic             sck_en_o;
   logic             pcm_valid_o;
   logic [23:0]      pcm_left_o;
   logic [23:0]      pcm_right_o;
   logic             pcm_ready_i;
   logic             busy_o;
   logic             done_o;
   logic             overflow_o;
   logic [CNT_W-1:0] pair_count_o;

   i2s_capture_ctrl #(
      .FIFO_DEPTH   (4),
      .DISCARD_PAIRS(2),
      .CNT_W        (CNT_W)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .stop_i       (stop_i),
      .num_pairs_i  (num_pairs_i),
      .frame_start_i(frame_start_i),
      .pair_ready_i (pair_ready_i),
      .left_i       (left_i),
      .right_i      (right_i),
      .sck_en_o     (sck_en_o),
      .pcm_valid_o  (pcm_valid_o),
      .pcm_left_o   (pcm_left_o),
      .pcm_right_o  (pcm_right_o),
      .pcm_ready_i  (pcm_ready_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .overflow_o   (overflow_o),
      .pair_count_o (pair_count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      bit          keep;
   } vec_t;

   int          tests = 0;
   int          fails = 0;
   int          done_cnt = 0;
   int          popped = 0;
   logic [47:0] exp_q[$];
   logic        prev_done = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard on the consumer side plus done/busy relationship.
   always @(negedge clk_i) begin
      if (rst_ni && pcm_valid_o && pcm_ready_i) begin
         popped++;
         if (exp_q.size() == 0) begin
            chk("unexpected_pop", {pcm_left_o, pcm_right_o}, 64'hDEAD);
         end else begin
            chk("pop_data", {pcm_left_o, pcm_right_o}, exp_q.pop_front());
         end
      end
      if (rst_ni && done_o) begin
         done_cnt++;
         chk("busy_at_done", busy_o, 1);
      end
      if (rst_ni && prev_done) begin
         chk("busy_after_done", busy_o, 0);
      end
      prev_done = done_o;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_start(input logic [CNT_W-1:0] n);
      num_pairs_i = n;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic do_frame();
      tick();
      frame_start_i = 1'b1;
      tick();
      frame_start_i = 1'b0;
   endtask

   task automatic send_pair(input logic [23:0] l, input logic [23:0] r, input bit keep, input int gap);
      if (keep) exp_q.push_back({l, r});
      left_i = l;
      right_i = r;
      pair_ready_i = 1'b1;
      tick();
      pair_ready_i = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic wait_done(input int d0, input string name);
      for (int i = 0; i < 60 && done_cnt == d0; i++) tick();
      chk(name, done_cnt, d0 + 1);
      repeat (2) tick();
   endtask

   vec_t tbl[6];
   int   d0;

   initial begin
      tbl[0] = '{24'h111111, 24'h222222, 1'b0};
      tbl[1] = '{24'h333333, 24'h444444, 1'b0};
      tbl[2] = '{24'hA5A5A5, 24'h5A5A5A, 1'b1};
      tbl[3] = '{24'h123456, 24'h789ABC, 1'b1};
      tbl[4] = '{24'hDEF012, 24'h345678, 1'b1};
      tbl[5] = '{24'h777777, 24'h888888, 1'b0};

      rst_ni = 1'b0; start_i = 1'b0; stop_i = 1'b0; num_pairs_i = '0;
      frame_start_i = 1'b0; pair_ready_i = 1'b0; left_i = '0; right_i = '0;
      pcm_ready_i = 1'b1;
      repeat (20) tick();
      chk("rst_valid", pcm_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_sck", sck_en_o, 0);
      chk("rst_ovf", overflow_o, 0);
      chk("rst_count", pair_count_o, 0);
      chk("rst_left", pcm_left_o, 0);
      rst_ni = 1'b1;
      tick();

      // 1: counted session, table driven
      d0 = done_cnt;
      do_start(3);
      chk("t1_busy", busy_o, 1);
      chk("t1_sck", sck_en_o, 1);
      do_frame();
      for (int i = 0; i < 6; i++) send_pair(tbl[i].l, tbl[i].r, tbl[i].keep, 5);
      chk("t1_done_once", done_cnt, d0 + 1);
      chk("t1_count", pair_count_o, 3);
      chk("t1_sck_off", sck_en_o, 0);
      chk("t1_busy_off", busy_o, 0);
      chk("t1_all_out", exp_q.size(), 0);

      // 2: continuous, consumer stalled, overflow then stop/drain
      pcm_ready_i = 1'b0;
      d0 = done_cnt;
      do_start(0);
      do_frame();
      send_pair(24'h010101, 24'h020202, 1'b0, 1);
      send_pair(24'h030303, 24'h040404, 1'b0, 1);
      for (int i = 0; i < 5; i++)
         send_pair(24'h100000 + 24'(i), 24'h200000 + 24'(i), i < 4, 1);
      chk("t2_ovf", overflow_o, 1);
      chk("t2_count", pair_count_o, 4);
      chk("t2_valid", pcm_valid_o, 1);
      chk("t2_head", {pcm_left_o, pcm_right_o}, {24'h100000, 24'h200000});
      stop_i = 1'b1;
      pcm_ready_i = 1'b1;
      tick();
      stop_i = 1'b0;
      wait_done(d0, "t2_done");
      chk("t2_drained", exp_q.size(), 0);
      chk("t2_ovf_sticky", overflow_o, 1);

      // 3: stop in SYNC, which also checks that start clears overflow
      d0 = done_cnt;
      do_start(5);
      chk("t3_ovf_clr", overflow_o, 0);
      chk("t3_count_clr", pair_count_o, 0);
      chk("t3_sck_on", sck_en_o, 1);
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      chk("t3_drain_busy", busy_o, 1);
      chk("t3_drain_sck", sck_en_o, 0);
      chk("t3_drain_nodone", done_o, 0);
      tick();
      chk("t3_done", done_o, 1);
      chk("t3_novalid", pcm_valid_o, 0);
      tick();
      chk("t3_idle", busy_o, 0);
      chk("t3_done_low", done_o, 0);
      chk("t3_count", pair_count_o, 0);

      // 4: stop coinciding with a pair
      d0 = done_cnt;
      do_start(0);
      do_frame();
      send_pair(24'h0A0A0A, 24'h0B0B0B, 1'b0, 1);
      send_pair(24'h0C0C0C, 24'h0D0D0D, 1'b0, 1);
      send_pair(24'hC0FFEE, 24'hBEEF00, 1'b1, 2);
      stop_i = 1'b1;
      send_pair(24'hFACADE, 24'h0DDBA1, 1'b1, 0);
      stop_i = 1'b0;
      chk("t4_count", pair_count_o, 2);
      wait_done(d0, "t4_done");
      send_pair(24'h999999, 24'hAAAAAA, 1'b0, 2);
      chk("t4_count_after", pair_count_o, 2);
      chk("t4_drained", exp_q.size(), 0);

      // 5: reset mid-stream with two entries queued
      pcm_ready_i = 1'b0;
      d0 = done_cnt;
      do_start(0);
      do_frame();
      send_pair(24'h0E0E0E, 24'h0F0F0F, 1'b0, 1);
      send_pair(24'h1E1E1E, 24'h1F1F1F, 1'b0, 1);
      chk("t5_empty", pcm_valid_o, 0);
      send_pair(24'h515151, 24'h525252, 1'b0, 0);
      chk("t5_latency", pcm_valid_o, 1);
      send_pair(24'h535353, 24'h545454, 1'b0, 1);
      chk("t5_count", pair_count_o, 2);
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      chk("t5_valid", pcm_valid_o, 0);
      chk("t5_sck", sck_en_o, 0);
      chk("t5_busy", busy_o, 0);
      chk("t5_left", pcm_left_o, 0);
      pcm_ready_i = 1'b1;
      repeat (8) tick();
      chk("t5_nodone", done_cnt, d0);

      // 6: start while busy is ignored
      d0 = done_cnt;
      do_start(2);
      do_frame();
      send_pair(24'h212121, 24'h222222, 1'b0, 1);
      send_pair(24'h232323, 24'h242424, 1'b0, 1);
      send_pair(24'h610001, 24'h620001, 1'b1, 1);
      num_pairs_i = 7;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("t6_busy", busy_o, 1);
      send_pair(24'h610002, 24'h620002, 1'b1, 0);
      wait_done(d0, "t6_done");
      send_pair(24'h610003, 24'h620003, 1'b0, 2);
      chk("t6_count", pair_count_o, 2);
      chk("t6_drained", exp_q.size(), 0);
      chk("t6_pops", popped, 3 + 4 + 2 + 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
